// File: rtl/binary_mul_pkg.sv
// Shared widths and types for the unsigned 8x8 multiplier.
package binary_mul_pkg;
  localparam int OP_W   = 8;
  localparam int PROD_W = 16;

  typedef logic [PROD_W-1:0] prod_t;
endpackage

// File: rtl/binary_mul_8_1_uni_full_adder.sv
// One-bit full adder; the building block of the CSA rows and the final adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  // Sum and majority carry.
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end
endmodule

// File: rtl/binary_mul_8_1_uni.sv
// Unsigned 8x8 multiplier: AND-array partial products, carry-save row
// reduction, ripple carry-propagate adder, one enabled output register.
module binary_mul_8_1_uni
  import binary_mul_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [OP_W-1:0]   A,
  input  logic [OP_W-1:0]   B,
  output logic [PROD_W-1:0] P
);
  localparam int ROWS = OP_W - 2;  // CSA rows needed to fold 8 vectors into 2

  // Partial products, already shifted to their weight.
  logic [OP_W-1:0][PROD_W-1:0] pp;

  // Redundant (sum, carry) pair after each CSA row; index 0 is the seed.
  logic [ROWS:0][PROD_W-1:0] sum_v;
  logic [ROWS:0][PROD_W-1:0] car_v;

  // Ripple carries of the final adder and the combinational product.
  logic [PROD_W-1:0] rc;
  prod_t             prod;

  genvar j, r, i;

  for (j = 0; j < OP_W; j++) begin : g_pp
    assign pp[j] = {{(PROD_W-OP_W){1'b0}}, A & {OP_W{B[j]}}} << j;
  end

  assign sum_v[0] = pp[0];
  assign car_v[0] = pp[1];

  // Each row compresses the running (sum, carry) pair with the next partial
  // product. A carry out of the MSB column would weigh 2^16; since the true
  // product fits in 16 bits, arithmetic mod 2^16 is exact, so the MSB column
  // only needs its sum bit.
  for (r = 0; r < ROWS; r++) begin : g_row
    assign car_v[r+1][0] = 1'b0;
    for (i = 0; i < PROD_W-1; i++) begin : g_col
      full_adder u_fa (
        .a   (sum_v[r][i]),
        .b   (car_v[r][i]),
        .cin (pp[r+2][i]),
        .s   (sum_v[r+1][i]),
        .cout(car_v[r+1][i+1])
      );
    end
    assign sum_v[r+1][PROD_W-1] = sum_v[r][PROD_W-1] ^ car_v[r][PROD_W-1]
                                ^ pp[r+2][PROD_W-1];
  end

  // Ripple carry-propagate adder merging the final redundant pair.
  assign rc[0] = 1'b0;
  for (i = 0; i < PROD_W-1; i++) begin : g_cpa
    full_adder u_fa (
      .a   (sum_v[ROWS][i]),
      .b   (car_v[ROWS][i]),
      .cin (rc[i]),
      .s   (prod[i]),
      .cout(rc[i+1])
    );
  end
  assign prod[PROD_W-1] = sum_v[ROWS][PROD_W-1] ^ car_v[ROWS][PROD_W-1]
                        ^ rc[PROD_W-1];

  // Output register: async clear, load on enable, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  P <= '0;
    else if (en) P <= prod;
  end
endmodule

// File: tb/tb_binary_mul_8_1_uni.sv
// Bench for binary_mul_8_1_uni: directed corners, exhaustive sweep with a
// mid-stream reset pulse, and randomized operands/enable against a
// behavioural product-register model.
module tb_binary_mul_8_1_uni;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [7:0]  A, B;
  logic [15:0] P;

  logic [15:0] m_p;      // model of the product register
  int          n_chk  = 0;
  int          n_pass = 0;

  binary_mul_8_1_uni dut (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .A    (A),
    .B    (B),
    .P    (P)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  // Drive at the falling edge, sample 1ns after the rising edge.
  task automatic step(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic e);
    @(negedge clk);
    A = a; B = b; en = e;
    @(posedge clk);
    if (rst_n && e) m_p = 16'(int'(a) * int'(b));
    #1;
    chk(tag, P, m_p);
  endtask

  logic [7:0] ca [6] = '{8'd0, 8'd255, 8'd1, 8'd255, 8'd255, 8'd128};
  logic [7:0] cb [6] = '{8'd0, 8'd0,   8'd255, 8'd127, 8'd255, 8'd128};
  logic [15:0] ce [6] = '{16'd0, 16'd0, 16'd255, 16'd32385, 16'd65025, 16'd16384};

  initial begin
    rst_n = 1'b0; en = 1'b1; A = 8'd200; B = 8'd100; m_p = '0;

    // Reset held: register stays clear despite enable.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("reset_hold", P, 16'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("first_after_reset", P, 16'd20000);
    m_p = 16'd20000;

    // Corners, with literal expected values.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); A = ca[k]; B = cb[k]; en = 1'b1;
      @(posedge clk); #1;
      chk("corner", P, ce[k]);
      m_p = ce[k];
    end

    // Back-to-back.
    step("b2b_15",  8'd3,   8'd5,  1'b1); chk("b2b_15_lit",  P, 16'd15);
    step("b2b_77",  8'd7,   8'd11, 1'b1); chk("b2b_77_lit",  P, 16'd77);
    step("b2b_510", 8'd255, 8'd2,  1'b1); chk("b2b_510_lit", P, 16'd510);

    // Enable hold.
    step("hold_load", 8'd17, 8'd13, 1'b1); chk("hold_load_lit", P, 16'd221);
    step("hold_off",  8'd50, 8'd50, 1'b0); chk("hold_off_lit",  P, 16'd221);
    step("hold_off2", 8'd50, 8'd50, 1'b0);
    step("hold_on",   8'd50, 8'd50, 1'b1); chk("hold_on_lit",   P, 16'd2500);

    // Exhaustive sweep with an asynchronous reset pulse between edges.
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        step("sweep", 8'(a), 8'(b), 1'b1);
        if (a == 117 && b == 42) begin
          #1 rst_n = 1'b0;
          #1 chk("async_clear", P, 16'd0);
          m_p = '0;
          #1 rst_n = 1'b1;
        end
      end
    end

    // Randomized operands and enable.
    for (int k = 0; k < 3000; k++)
      step("random", 8'($urandom), 8'($urandom), ($urandom_range(0, 9) < 7));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
